// File: rtl/regfile_2r1w.sv
// regfile_2r1w: parametrised register file with two combinational read ports,
// one synchronous write port, optional write-to-read bypass and a per-register
// pending scoreboard for producer/consumer tracking.
module regfile_2r1w #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 3,
  parameter int BYPASS  = 1,
  parameter int ZERO_R0 = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [DATA_W-1:0]       data_in,
  input  logic [ADDR_W-1:0]       writenum,
  input  logic                    write,
  input  logic [ADDR_W-1:0]       readnum_a,
  input  logic [ADDR_W-1:0]       readnum_b,
  output logic [DATA_W-1:0]       data_out_a,
  output logic [DATA_W-1:0]       data_out_b,
  input  logic                    reserve,
  input  logic [ADDR_W-1:0]       reservenum,
  output logic                    busy_a,
  output logic                    busy_b,
  output logic [(1<<ADDR_W)-1:0]  pending
);

  localparam int NREGS = 1 << ADDR_W;

  logic [DATA_W-1:0] regs [NREGS];
  logic [NREGS-1:0]  pending_nxt;
  logic              r0_hard;
  logic              wr_store;
  logic              byp_a;
  logic              byp_b;

  assign r0_hard  = (ZERO_R0 != 0);
  // Writes to a hardwired-zero R0 never reach storage.
  assign wr_store = write && !(r0_hard && (writenum == '0));

  // Register storage: synchronous clear, single write port.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_store) begin
      regs[writenum] <= data_in;
    end
  end

  // Scoreboard next state: reserve takes priority over a same-register write.
  always_comb begin
    pending_nxt = pending;
    for (int unsigned i = 0; i < NREGS; i++) begin
      if (reserve && (reservenum == ADDR_W'(i)) && !(r0_hard && (i == 0))) begin
        pending_nxt[i] = 1'b1;
      end else if (write && (writenum == ADDR_W'(i))) begin
        pending_nxt[i] = 1'b0;
      end
    end
  end

  // Scoreboard register.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= '0;
    end else begin
      pending <= pending_nxt;
    end
  end

  // Read ports with same-cycle bypass, suppressed during reset.
  always_comb begin
    byp_a = (BYPASS != 0) && write && !reset && (writenum == readnum_a);
    byp_b = (BYPASS != 0) && write && !reset && (writenum == readnum_b);

    if (r0_hard && (readnum_a == '0)) begin
      data_out_a = '0;
    end else if (byp_a) begin
      data_out_a = data_in;
    end else begin
      data_out_a = regs[readnum_a];
    end

    if (r0_hard && (readnum_b == '0)) begin
      data_out_b = '0;
    end else if (byp_b) begin
      data_out_b = data_in;
    end else begin
      data_out_b = regs[readnum_b];
    end

    busy_a = pending[readnum_a] & ~byp_a;
    busy_b = pending[readnum_b] & ~byp_b;
  end

endmodule

// File: tb/tb_regfile_2r1w.sv
// Directed, table-driven bench for regfile_2r1w. Three instances share the
// same stimulus: default (BYPASS=1, ZERO_R0=0), no-bypass, and zero-R0.
module tb_regfile_2r1w;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] data_in;
  logic [2:0]  writenum;
  logic        write;
  logic [2:0]  readnum_a;
  logic [2:0]  readnum_b;
  logic        reserve;
  logic [2:0]  reservenum;

  logic [15:0] m_a, m_b, n_a, n_b, z_a, z_b;
  logic        m_ba, m_bb, n_ba, n_bb, z_ba, z_bb;
  logic [7:0]  m_p, n_p, z_p;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  regfile_2r1w #(.DATA_W(16), .ADDR_W(3), .BYPASS(1), .ZERO_R0(0)) u_main (
    .clk(clk), .reset(reset), .data_in(data_in), .writenum(writenum), .write(write),
    .readnum_a(readnum_a), .readnum_b(readnum_b), .data_out_a(m_a), .data_out_b(m_b),
    .reserve(reserve), .reservenum(reservenum), .busy_a(m_ba), .busy_b(m_bb), .pending(m_p));

  regfile_2r1w #(.DATA_W(16), .ADDR_W(3), .BYPASS(0), .ZERO_R0(0)) u_nobyp (
    .clk(clk), .reset(reset), .data_in(data_in), .writenum(writenum), .write(write),
    .readnum_a(readnum_a), .readnum_b(readnum_b), .data_out_a(n_a), .data_out_b(n_b),
    .reserve(reserve), .reservenum(reservenum), .busy_a(n_ba), .busy_b(n_bb), .pending(n_p));

  regfile_2r1w #(.DATA_W(16), .ADDR_W(3), .BYPASS(1), .ZERO_R0(1)) u_zero (
    .clk(clk), .reset(reset), .data_in(data_in), .writenum(writenum), .write(write),
    .readnum_a(readnum_a), .readnum_b(readnum_b), .data_out_a(z_a), .data_out_b(z_b),
    .reserve(reserve), .reservenum(reservenum), .busy_a(z_ba), .busy_b(z_bb), .pending(z_p));

  typedef struct {
    logic        wr;
    logic [2:0]  wn;
    logic [15:0] d;
    logic        rs;
    logic [2:0]  rn;
    logic [2:0]  ra;
    logic [2:0]  rb;
    logic [15:0] exp_a;
    logic [15:0] exp_b;
    logic        exp_ba;
    logic        exp_bb;
    logic [7:0]  exp_p;
    logic [15:0] exp_na;
    logic [15:0] exp_za;
    logic [7:0]  exp_zp;
  } vec_t;

  vec_t vecs [15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    reset = 1'b0; write = 1'b0; reserve = 1'b0;
    data_in = '0; writenum = '0; reservenum = '0;
  endtask

  initial begin
    // wr wn d rs rn ra rb | a b ba bb pend | nobyp_a zero_a zero_pend
    vecs[0]  = '{1, 3, 16'hBEEF, 0, 0, 4, 3, 16'h0000, 16'hBEEF, 0, 0, 8'h00, 16'h0000, 16'h0000, 8'h00};
    vecs[1]  = '{0, 0, 16'h0000, 0, 0, 3, 3, 16'hBEEF, 16'hBEEF, 0, 0, 8'h00, 16'hBEEF, 16'hBEEF, 8'h00};
    vecs[2]  = '{1, 5, 16'h1234, 0, 0, 5, 4, 16'h1234, 16'h0000, 0, 0, 8'h00, 16'h0000, 16'h1234, 8'h00};
    vecs[3]  = '{0, 0, 16'h0000, 0, 0, 5, 5, 16'h1234, 16'h1234, 0, 0, 8'h00, 16'h1234, 16'h1234, 8'h00};
    vecs[4]  = '{0, 0, 16'h0000, 1, 2, 2, 2, 16'h0000, 16'h0000, 0, 0, 8'h00, 16'h0000, 16'h0000, 8'h00};
    vecs[5]  = '{0, 0, 16'h0000, 0, 0, 2, 0, 16'h0000, 16'h0000, 1, 0, 8'h04, 16'h0000, 16'h0000, 8'h04};
    vecs[6]  = '{1, 2, 16'h00AA, 0, 0, 2, 2, 16'h00AA, 16'h00AA, 0, 0, 8'h04, 16'h0000, 16'h00AA, 8'h04};
    vecs[7]  = '{0, 0, 16'h0000, 0, 0, 2, 3, 16'h00AA, 16'hBEEF, 0, 0, 8'h00, 16'h00AA, 16'h00AA, 8'h00};
    vecs[8]  = '{1, 6, 16'h5555, 1, 6, 6, 1, 16'h5555, 16'h0000, 0, 0, 8'h00, 16'h0000, 16'h5555, 8'h00};
    vecs[9]  = '{0, 0, 16'h0000, 0, 0, 6, 6, 16'h5555, 16'h5555, 1, 1, 8'h40, 16'h5555, 16'h5555, 8'h40};
    vecs[10] = '{1, 0, 16'h7777, 1, 0, 0, 6, 16'h7777, 16'h5555, 0, 1, 8'h40, 16'h0000, 16'h0000, 8'h40};
    vecs[11] = '{0, 0, 16'h0000, 0, 0, 0, 0, 16'h7777, 16'h7777, 1, 1, 8'h41, 16'h7777, 16'h0000, 8'h40};
    vecs[12] = '{1, 0, 16'h1111, 0, 0, 0, 5, 16'h1111, 16'h1234, 0, 0, 8'h41, 16'h7777, 16'h0000, 8'h40};
    vecs[13] = '{1, 6, 16'h0001, 0, 0, 1, 6, 16'h0000, 16'h0001, 0, 0, 8'h40, 16'h0000, 16'h0000, 8'h40};
    vecs[14] = '{0, 0, 16'h0000, 0, 0, 0, 6, 16'h1111, 16'h0001, 0, 0, 8'h00, 16'h1111, 16'h0000, 8'h00};

    idle();
    readnum_a = '0; readnum_b = '0;

    // Reset cycle with a competing write and reserve of R1; both must be discarded.
    @(negedge clk);
    reset = 1'b1; write = 1'b1; writenum = 3'd1; data_in = 16'hFFFF;
    reserve = 1'b1; reservenum = 3'd1;
    @(negedge clk);
    idle();

    // Every register reads zero on both ports after reset.
    for (int i = 0; i < 8; i++) begin
      readnum_a = 3'(i);
      readnum_b = 3'(7 - i);
      #2;
      check("reset_read_a", {16'h0, m_a}, 32'h0);
      check("reset_read_b", {16'h0, m_b}, 32'h0);
      check("reset_pending", {24'h0, m_p}, 32'h0);
      check("reset_pending_zero", {24'h0, z_p}, 32'h0);
      @(negedge clk);
    end

    // Table-driven main sequence: inputs applied at negedge, outputs checked before next posedge.
    for (int i = 0; i < 15; i++) begin
      write = vecs[i].wr; writenum = vecs[i].wn; data_in = vecs[i].d;
      reserve = vecs[i].rs; reservenum = vecs[i].rn;
      readnum_a = vecs[i].ra; readnum_b = vecs[i].rb;
      #2;
      check($sformatf("v%0d_data_a", i), {16'h0, m_a}, {16'h0, vecs[i].exp_a});
      check($sformatf("v%0d_data_b", i), {16'h0, m_b}, {16'h0, vecs[i].exp_b});
      check($sformatf("v%0d_busy_a", i), {31'h0, m_ba}, {31'h0, vecs[i].exp_ba});
      check($sformatf("v%0d_busy_b", i), {31'h0, m_bb}, {31'h0, vecs[i].exp_bb});
      check($sformatf("v%0d_pending", i), {24'h0, m_p}, {24'h0, vecs[i].exp_p});
      check($sformatf("v%0d_nobyp_a", i), {16'h0, n_a}, {16'h0, vecs[i].exp_na});
      check($sformatf("v%0d_zero_a", i), {16'h0, z_a}, {16'h0, vecs[i].exp_za});
      check($sformatf("v%0d_zero_pending", i), {24'h0, z_p}, {24'h0, vecs[i].exp_zp});
      check($sformatf("v%0d_zero_busy_r0", i), {31'h0, (readnum_a == 3'd0) & z_ba}, 32'h0);
      @(negedge clk);
    end

    // Reset while writing R2: bypass must be inactive, storage cleared afterwards.
    reset = 1'b1; write = 1'b1; writenum = 3'd2; data_in = 16'h9999;
    reserve = 1'b1; reservenum = 3'd2;
    readnum_a = 3'd2; readnum_b = 3'd6;
    #2;
    check("rst_no_bypass_a", {16'h0, m_a}, 32'h0000_00AA);
    check("rst_no_bypass_b", {16'h0, m_b}, 32'h0000_0001);
    @(negedge clk);
    idle();
    readnum_a = 3'd2; readnum_b = 3'd0;
    #2;
    check("post_rst_a", {16'h0, m_a}, 32'h0);
    check("post_rst_b", {16'h0, m_b}, 32'h0);
    check("post_rst_pending", {24'h0, m_p}, 32'h0);
    check("post_rst_busy_a", {31'h0, m_ba}, 32'h0);
    check("post_rst_nobyp_a", {16'h0, n_a}, 32'h0);
    check("post_rst_pending_nobyp", {24'h0, n_p}, 32'h0);

    // No-bypass instance: a write to a reserved register leaves busy set that cycle.
    @(negedge clk);
    reserve = 1'b1; reservenum = 3'd4;
    @(negedge clk);
    idle();
    write = 1'b1; writenum = 3'd4; data_in = 16'hCAFE; readnum_a = 3'd4;
    #2;
    check("nobyp_busy_during_write", {31'h0, n_ba}, 32'h1);
    check("nobyp_old_data", {16'h0, n_a}, 32'h0);
    check("byp_busy_during_write", {31'h0, m_ba}, 32'h0);
    check("byp_new_data", {16'h0, m_a}, 32'h0000_CAFE);
    @(negedge clk);
    idle();
    readnum_a = 3'd4;
    #2;
    check("nobyp_after_write_data", {16'h0, n_a}, 32'h0000_CAFE);
    check("nobyp_after_write_pending", {24'h0, n_p}, 32'h0);

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got time %0t required < 100000", $time);
    $fatal(1);
  end

endmodule
